// File: rtl/guess_history.sv
// Per-player circular history of guesses with strike/ball results, registered readout and winner latch.
// Optional duplicate-guess rejection is enabled by defining GUESS_HIST_DUP_CHECK_EN.
module guess_history #(
   parameter int NUM_PLAYERS = 2,
   parameter int DEPTH       = 4,
   parameter int DIGITS      = 3
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         on_game,
   input  logic [NUM_PLAYERS-1:0]                       push,
   input  logic [DIGITS*4-1:0]                          guess_in,
   input  logic [NUM_PLAYERS*$clog2(DIGITS+1)-1:0]      strike_in,
   input  logic [NUM_PLAYERS*$clog2(DIGITS+1)-1:0]      ball_in,
   input  logic [((NUM_PLAYERS>2)?$clog2(NUM_PLAYERS):1)-1:0] rd_player,
   input  logic [$clog2(DEPTH)-1:0]                     rd_entry,
   input  logic [$clog2(DIGITS+2)-1:0]                  rd_field,
   output logic [3:0]                                   rd_data,
   output logic [$clog2(DEPTH+1)-1:0]                   rd_count,
   output logic [$clog2(NUM_PLAYERS+1)-1:0]             winner,
   output logic                                         dup
);

   localparam int SW  = $clog2(DIGITS+1);
   localparam int GW  = DIGITS*4;
   localparam int PW  = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
   localparam int PW1 = PW + 1;
   localparam int EW  = $clog2(DEPTH);
   localparam int FW  = $clog2(DIGITS+2);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int WW  = $clog2(NUM_PLAYERS+1);

   logic [GW-1:0]  r_guess  [NUM_PLAYERS][DEPTH];
   logic [SW-1:0]  r_strike [NUM_PLAYERS][DEPTH];
   logic [SW-1:0]  r_ball   [NUM_PLAYERS][DEPTH];
   logic [EW-1:0]  r_wp     [NUM_PLAYERS];
   logic [CW-1:0]  r_cnt    [NUM_PLAYERS];
   logic [WW-1:0]  r_winner;
   logic [3:0]     r_rd_data;
   logic [CW-1:0]  r_rd_count;

   logic [NUM_PLAYERS-1:0] w_gate;
   logic [NUM_PLAYERS-1:0] w_dup_hit;
   logic [NUM_PLAYERS-1:0] w_acc;
   logic [WW-1:0]          w_win_next;
   logic                   w_pl_ok;
   logic [PW-1:0]          w_pidx;
   logic [EW-1:0]          w_slot;
   logic                   w_ent_ok;
   logic [GW-1:0]          w_sel_guess;
   logic [SW-1:0]          w_sel_strike;
   logic [SW-1:0]          w_sel_ball;
   logic [GW-1:0]          w_shifted;
   logic [3:0]             w_rd_next;
   logic [CW-1:0]          w_cnt_next;

   // Pushes only count while a game is running and nobody has won yet.
   assign w_gate = push & {NUM_PLAYERS{on_game && (r_winner == '0)}};
   assign w_acc  = w_gate & ~w_dup_hit;

`ifdef GUESS_HIST_DUP_CHECK_EN
   logic r_dup;

   // Match the incoming guess against every valid slot of each player.
   always_comb begin
      w_dup_hit = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         for (int e = 0; e < DEPTH; e++) begin
            w_dup_hit[p] = w_dup_hit[p] | ((CW'(e) < r_cnt[p]) && (r_guess[p][e] == guess_in));
         end
      end
   end

   // Single-cycle pulse for a rejected duplicate.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_dup <= 1'b0;
      end else begin
         r_dup <= |(w_gate & w_dup_hit);
      end
   end

   assign dup = r_dup;
`else
   assign w_dup_hit = '0;
   assign dup       = 1'b0;
`endif

   // Descending scan so the lowest-index winner overrides higher ones.
   always_comb begin
      w_win_next = r_winner;
      for (int p = NUM_PLAYERS-1; p >= 0; p--) begin
         w_win_next = (w_acc[p] && (strike_in[p*SW +: SW] == SW'(DIGITS))) ? WW'(p+1) : w_win_next;
      end
   end

   // Readout select from pre-push state; newest entry sits just behind the write pointer.
   always_comb begin
      w_pl_ok      = PW1'(rd_player) < PW1'(NUM_PLAYERS);
      w_pidx       = w_pl_ok ? rd_player : '0;
      w_slot       = r_wp[w_pidx] - EW'(1) - rd_entry;
      w_ent_ok     = CW'(rd_entry) < r_cnt[w_pidx];
      w_sel_guess  = r_guess[w_pidx][w_slot];
      w_sel_strike = r_strike[w_pidx][w_slot];
      w_sel_ball   = r_ball[w_pidx][w_slot];
      w_shifted    = '0;
      w_rd_next    = 4'd0;
      if (!w_pl_ok || !w_ent_ok) begin
         w_rd_next = 4'd0;
      end else if (rd_field < FW'(DIGITS)) begin
         w_shifted = w_sel_guess >> (4*(DIGITS-1-int'(rd_field)));
         w_rd_next = w_shifted[3:0];
      end else if (rd_field == FW'(DIGITS)) begin
         w_rd_next = 4'(w_sel_ball);
      end else if (rd_field == FW'(DIGITS+1)) begin
         w_rd_next = 4'(w_sel_strike);
      end else begin
         w_rd_next = 4'd0;
      end
      w_cnt_next = w_pl_ok ? r_cnt[w_pidx] : '0;
   end

   // History buffers, winner latch and readout registers; reset overrides any push.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            r_wp[p]  <= '0;
            r_cnt[p] <= '0;
            for (int e = 0; e < DEPTH; e++) begin
               r_guess[p][e]  <= '0;
               r_strike[p][e] <= '0;
               r_ball[p][e]   <= '0;
            end
         end
         r_winner   <= '0;
         r_rd_data  <= 4'd0;
         r_rd_count <= '0;
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_acc[p]) begin
               r_guess[p][r_wp[p]]  <= guess_in;
               r_strike[p][r_wp[p]] <= strike_in[p*SW +: SW];
               r_ball[p][r_wp[p]]   <= ball_in[p*SW +: SW];
               r_wp[p]              <= r_wp[p] + EW'(1);
               if (r_cnt[p] != CW'(DEPTH)) begin
                  r_cnt[p] <= r_cnt[p] + CW'(1);
               end else begin
                  r_cnt[p] <= r_cnt[p];
               end
            end else begin
               r_wp[p]  <= r_wp[p];
               r_cnt[p] <= r_cnt[p];
            end
         end
         r_winner   <= w_win_next;
         r_rd_data  <= w_rd_next;
         r_rd_count <= w_cnt_next;
      end
   end

   assign rd_data  = r_rd_data;
   assign rd_count = r_rd_count;
   assign winner   = r_winner;

endmodule

// File: tb/tb_guess_history.sv
// Scoreboard bench for guess_history: stimulus queues expectations from a list-based history model,
// a negedge monitor pops and compares them.
module tb_guess_history;

   logic        clk;
   logic        rst;
   logic        on_game;
   logic [1:0]  push;
   logic [11:0] guess_in;
   logic [3:0]  strike_in;
   logic [3:0]  ball_in;
   logic        rd_player;
   logic [1:0]  rd_entry;
   logic [2:0]  rd_field;
   logic [3:0]  rd_data;
   logic [2:0]  rd_count;
   logic [1:0]  winner;
   logic        dup;

   guess_history dut (
      .clk(clk), .rst(rst), .on_game(on_game), .push(push), .guess_in(guess_in),
      .strike_in(strike_in), .ball_in(ball_in), .rd_player(rd_player), .rd_entry(rd_entry),
      .rd_field(rd_field), .rd_data(rd_data), .rd_count(rd_count), .winner(winner), .dup(dup)
   );

   typedef struct {
      int    cyc;
      int    d;
      int    c;
      int    w;
      int    du;
      string nm;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   n_cmp;
   int   n_bad;

   // History model: index 0 is the newest guess, list capped at four entries.
   logic [11:0] m_g [2][4];
   int          m_s [2][4];
   int          m_b [2][4];
   int          m_n [2];
   int          m_win;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: compare every expectation whose sampling edge has passed.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            x = sb.pop_front();
            chk({x.nm, ".rd_data"},  32'(rd_data),  x.d);
            chk({x.nm, ".rd_count"}, 32'(rd_count), x.c);
            chk({x.nm, ".winner"},   32'(winner),   x.w);
            chk({x.nm, ".dup"},      32'(dup),      x.du);
         end
      end
   end

   task automatic step(input bit r, input bit on, input bit [1:0] pu, input logic [11:0] g,
                       input int s0, input int s1, input int b0, input int b1,
                       input int rp, input int re, input int rf, input string nm);
      exp_t x;
      int   st[2];
      int   bl[2];
      bit   hit;
      bit   dflag;
      int   nw;
      @(posedge clk);
      #1;
      rst       = r;
      on_game   = on;
      push      = pu;
      guess_in  = g;
      strike_in = {2'(s1), 2'(s0)};
      ball_in   = {2'(b1), 2'(b0)};
      rd_player = 1'(rp);
      rd_entry  = 2'(re);
      rd_field  = 3'(rf);
      st[0] = s0; st[1] = s1; bl[0] = b0; bl[1] = b1;
      x.cyc = cyc + 1;
      x.nm  = nm;
      if (!r) begin
         x.d = 0; x.c = 0; x.w = 0; x.du = 0;
         m_n[0] = 0; m_n[1] = 0; m_win = 0;
      end else begin
         x.d = 0;
         if (re < m_n[rp]) begin
            if (rf < 3)       x.d = int'((m_g[rp][re] >> (4*(2-rf))) & 12'hf);
            else if (rf == 3) x.d = m_b[rp][re];
            else if (rf == 4) x.d = m_s[rp][re];
         end
         x.c   = m_n[rp];
         nw    = m_win;
         dflag = 1'b0;
         for (int p = 0; p < 2; p++) begin
            if (pu[p] && on && m_win == 0) begin
               hit = 1'b0;
`ifdef GUESS_HIST_DUP_CHECK_EN
               for (int i = 0; i < m_n[p]; i++) if (m_g[p][i] == g) hit = 1'b1;
`endif
               if (hit) begin
                  dflag = 1'b1;
               end else begin
                  for (int i = 3; i > 0; i--) begin
                     m_g[p][i] = m_g[p][i-1];
                     m_s[p][i] = m_s[p][i-1];
                     m_b[p][i] = m_b[p][i-1];
                  end
                  m_g[p][0] = g; m_s[p][0] = st[p]; m_b[p][0] = bl[p];
                  if (m_n[p] < 4) m_n[p]++;
                  if (st[p] == 3 && nw == 0) nw = p + 1;
               end
            end
         end
         m_win = nw;
         x.w   = nw;
         x.du  = dflag ? 1 : 0;
      end
      sb.push_back(x);
   endtask

   task automatic rd(input int rp, input int re, input int rf, input string nm);
      step(1'b1, 1'b1, 2'b00, 12'h000, 0, 0, 0, 0, rp, re, rf, nm);
   endtask

   task automatic do_reset(input string nm);
      step(1'b0, 1'b0, 2'b00, 12'h000, 0, 0, 0, 0, 0, 0, 0, nm);
   endtask

   initial begin
      bit       r;
      bit       on;
      bit [1:0] pu;
      logic [11:0] g;
      int       s0, s1;
      cyc = 0; n_cmp = 0; n_bad = 0;
      rst = 1'b0; on_game = 1'b0; push = 2'b00; guess_in = 12'h000;
      strike_in = 4'h0; ball_in = 4'h0; rd_player = 1'b0; rd_entry = 2'd0; rd_field = 3'd0;
      m_n[0] = 0; m_n[1] = 0; m_win = 0;

      do_reset("reset0");
      do_reset("reset1");

      step(1'b1, 1'b1, 2'b01, 12'h123, 1, 0, 1, 0, 0, 0, 0, "push123");
      for (int f = 0; f < 8; f++) rd(0, 0, f, "read123");
      rd(0, 1, 0, "read_empty_entry");

      do_reset("reset_wrap");
      for (int k = 1; k <= 5; k++) step(1'b1, 1'b1, 2'b01, 12'(k * 12'h111), 0, 0, 2, 0, 0, 0, 0, "push_wrap");
      for (int e = 0; e < 4; e++) for (int f = 0; f < 3; f++) rd(0, e, f, "read_wrap");

      do_reset("reset_win");
      step(1'b1, 1'b1, 2'b11, 12'h321, 3, 3, 0, 0, 1, 0, 0, "double_win");
      step(1'b1, 1'b1, 2'b10, 12'h987, 1, 1, 1, 1, 1, 0, 0, "push_after_win");
      rd(1, 0, 0, "p1_after_win");
      rd(1, 1, 0, "p1_entry1_after_win");

      do_reset("reset_rp");
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 2'b01, 12'(12'h400 + k), 0, 0, 0, 0, 0, 0, 0, "fill3");
      step(1'b0, 1'b1, 2'b01, 12'h777, 3, 0, 0, 0, 0, 0, 0, "reset_with_push");
      for (int e = 0; e < 4; e++) rd(0, e, 0, "read_after_reset");

      step(1'b1, 1'b1, 2'b10, 12'h456, 0, 1, 0, 2, 1, 0, 0, "dup_first");
      step(1'b1, 1'b1, 2'b10, 12'h456, 0, 1, 0, 2, 1, 0, 0, "dup_second");
      rd(1, 0, 4, "after_dup");
      rd(1, 1, 2, "after_dup_e1");

      do_reset("reset_on");
      step(1'b1, 1'b1, 2'b10, 12'h135, 0, 2, 0, 1, 1, 0, 0, "p1_one");
      step(1'b1, 1'b0, 2'b10, 12'h246, 0, 3, 0, 0, 1, 0, 0, "on_game_low");
      rd(1, 2, 0, "entry_past_count");
      rd(1, 0, 2, "retained");

      for (int it = 0; it < 600; it++) begin
         r  = ($urandom_range(0, 39) != 0);
         on = ($urandom_range(0, 9) != 0);
         pu = 2'($urandom_range(0, 3));
         g  = {4'($urandom_range(1, 3)), 4'($urandom_range(1, 3)), 4'($urandom_range(0, 9))};
         s0 = ($urandom_range(0, 29) == 0) ? 3 : int'($urandom_range(0, 2));
         s1 = ($urandom_range(0, 29) == 0) ? 3 : int'($urandom_range(0, 2));
         step(r, on, pu, g, s0, s1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), "rand");
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (sb.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, 0 required", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/guess_history.md
GUESS_HISTORY -- requirements
Module: guess_history

Interface
- REQ-001 Parameter NUM_PLAYERS, default 2, SHALL set the number of independent player history buffers (range 2..4).
- REQ-002 Parameter DEPTH, default 4, SHALL set the entries per player; it SHALL be a power of two, at least 2.
- REQ-003 Parameter DIGITS, default 3, SHALL set the number of 4-bit digits per guess; SW = $clog2(DIGITS+1) is the strike/ball field width.
- REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
- REQ-005 rst  input  1  reset, synchronous and active-low: state clears on the rising clk edge while rst=0.
- REQ-006 on_game  input  1  game active; pushes SHALL be ignored while 0.
- REQ-007 push  input  NUM_PLAYERS  one bit per player, a single-cycle store request.
- REQ-008 guess_in  input  DIGITS*4  guessed number, most significant digit in the top nibble.
- REQ-009 strike_in  input  NUM_PLAYERS*SW  strike count per player, player p in slice p.
- REQ-010 ball_in  input  NUM_PLAYERS*SW  ball count per player, player p in slice p.
- REQ-011 rd_player  input  max(1,$clog2(NUM_PLAYERS))  player selected for readout.
- REQ-012 rd_entry  input  $clog2(DEPTH)  entry selected for readout, 0 = newest.
- REQ-013 rd_field  input  $clog2(DIGITS+2)  field select: 0..DIGITS-1 are digits, MSD first; DIGITS = ball; DIGITS+1 = strike.
- REQ-014 rd_data  output  4  registered readout nibble; strike/ball values are zero-extended.
- REQ-015 rd_count  output  $clog2(DEPTH+1)  number of valid entries for rd_player, registered.
- REQ-016 winner  output  $clog2(NUM_PLAYERS+1)  0 = none; otherwise the winning player index + 1.
- REQ-017 dup  output  1  one-cycle pulse on a rejected duplicate (see Configuration).

Function
- REQ-018 Each player SHALL own a circular buffer with a write pointer and a valid count; buffers are fully independent.
- REQ-019 A push is accepted for player p when push[p]=1, on_game=1 and winner=0; the guess, strike and ball are stored at the write pointer on that edge.
- REQ-020 On an accepted push the write pointer SHALL advance modulo DEPTH, and the count SHALL increment, saturating at DEPTH.
- REQ-021 When a buffer is full, an accepted push SHALL overwrite the oldest entry; the newest entry is always rd_entry=0.
- REQ-022 Simultaneous pushes by several players in one cycle SHALL all be accepted.
- REQ-023 rd_data and rd_count SHALL reflect the inputs and stored state sampled at edge N, valid after edge N (1-cycle latency).
- REQ-024 A push and a read of the same player in the same cycle SHALL return the pre-push contents.
- REQ-025 rd_data SHALL be 0 when rd_entry >= count, rd_field > DIGITS+1, or rd_player >= NUM_PLAYERS.
- REQ-026 An accepted push with strike = DIGITS SHALL set winner to p+1 on that edge; winner holds until reset.
- REQ-027 If several players win in the same cycle, the lowest player index SHALL win.
- REQ-028 Once winner != 0, all pushes SHALL be ignored; readout continues to operate.
- REQ-029 If on_game falls mid-game, the buffers and winner SHALL be retained.

Reset
- REQ-030 With rst=0 at a clk edge, all pointers, counts and stored entries SHALL clear, and rd_data=0, rd_count=0, winner=0, dup=0.
- REQ-031 Reset SHALL take priority over a push in the same cycle; that push is discarded.

Configuration
- REQ-032 Macro GUESS_HIST_DUP_CHECK_EN defined: a push whose guess_in equals any valid stored guess of that player SHALL NOT be stored, SHALL NOT change the pointer, count or winner, and SHALL pulse dup for one cycle.
- REQ-033 Macro undefined: the comparison logic SHALL be absent, duplicates SHALL be stored normally, and dup SHALL be tied to 0.

Verification (defaults: NUM_PLAYERS=2, DEPTH=4, DIGITS=3)
- REQ-034 Push P0 guess 0x123 (strike 1, ball 1), then read P0, entry 0, fields 0/1/2/3/4 -> rd_data 1, 2, 3, 1, 1 one cycle later; rd_count = 1.
- REQ-035 Push P0 guesses 0x111..0x555 (five pushes) -> rd_count = 4; entry 0 digit 0 = 5; entry 3 digit 0 = 2; entry 3 is 0x222 because 0x111 was overwritten.
- REQ-036 Same cycle, P0 pushes strike=3 and P1 pushes strike=3 -> winner = 1; a later P1 push is ignored and P1 rd_count stays 1.
- REQ-037 Hold rst=0 for one edge with push[0]=1 after three entries -> rd_count = 0, winner = 0, all rd_data reads = 0.
- REQ-038 Macro defined, P1 pushes 0x456 twice -> the second push gives dup high for exactly one cycle and rd_count = 1; macro undefined -> rd_count = 2 and dup = 0.
- REQ-039 on_game=0 with push[1]=1 -> no change; rd_entry=2 with count 1 -> rd_data = 0.
